td4_exec_unit: RTL and testbench

Single-cycle execute/register stage of the TD4 4-bit CPU. It holds registers A, B, OUT, the program counter and the carry flag, and decodes the instruction fetched from program ROM. It drives the existing `ALU` with the selected source and immediate, then commits `Y` and `C` on the next rising edge. It sits between the ROM (upstream, addressed by the PC) and the ALU (downstream combinational, result fed back).

---
 rtl/td4_pkg.sv | 37 +++
 rtl/alu.sv | 16 +
 rtl/td4_decoder.sv | 42 ++++
 rtl/td4_exec_unit.sv | 79 +++++++
 tb/tb_td4_exec_unit.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 4-bit CPU execute stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package td4_pkg;

   // Opcodes, upper four bits of the instruction word
   localparam logic [3:0] OP_ADD_A   = 4'b0000;
   localparam logic [3:0] OP_MOV_A_B = 4'b0001;
   localparam logic [3:0] OP_IN_A    = 4'b0010;
   localparam logic [3:0] OP_MOV_A   = 4'b0011;
   localparam logic [3:0] OP_MOV_B_A = 4'b0100;
   localparam logic [3:0] OP_ADD_B   = 4'b0101;
   localparam logic [3:0] OP_IN_B    = 4'b0110;
   localparam logic [3:0] OP_MOV_B   = 4'b0111;
   localparam logic [3:0] OP_OUT_B   = 4'b1001;
   localparam logic [3:0] OP_OUT_IM  = 4'b1011;
   localparam logic [3:0] OP_JNC     = 4'b1110;
   localparam logic [3:0] OP_JMP     = 4'b1111;

   // ALU A-operand source
   typedef enum logic [1:0] {
      SRC_A,
      SRC_B,
      SRC_IN,
      SRC_ZERO
   } src_t;

   // Register written by the instruction
   typedef enum logic [2:0] {
      DST_A,
      DST_B,
      DST_OUT,
      DST_PC,
      DST_NONE
   } dst_t;

endpackage

// File: rtl/alu.sv
// Combinational N-bit adder used as the TD4 ALU; Y = A + B mod 2^N, C = carry out.
// Latency: combinational.
// Backpressure: none.
// Ports: A, B operands; Y sum; C carry out.
module ALU #(
   parameter int N = 4
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] Y,
   output logic         C
);

   assign {C, Y} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/td4_decoder.sv
// Instruction decoder: opcode + carry flag -> source select, destination, jump taken.
// Latency: combinational.
// Backpressure: none.
// Ports: opcode, carry in; src, dst, jump out.
module td4_decoder
   import td4_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       carry,
   output src_t       src,
   output dst_t       dst,
   output logic       jump
);

   always_comb begin
      src  = SRC_ZERO;
      dst  = DST_NONE;
      jump = 1'b0;
      case (opcode)
         OP_ADD_A:   begin src = SRC_A;  dst = DST_A;   end
         OP_ADD_B:   begin src = SRC_B;  dst = DST_B;   end
         OP_MOV_A:   begin src = SRC_ZERO; dst = DST_A; end
         OP_MOV_B:   begin src = SRC_ZERO; dst = DST_B; end
         OP_MOV_A_B: begin src = SRC_B;  dst = DST_A;   end
         OP_MOV_B_A: begin src = SRC_A;  dst = DST_B;   end
         OP_IN_A:    begin src = SRC_IN; dst = DST_A;   end
         OP_IN_B:    begin src = SRC_IN; dst = DST_B;   end
         OP_OUT_B:   begin src = SRC_B;  dst = DST_OUT; end
         OP_OUT_IM:  begin src = SRC_ZERO; dst = DST_OUT; end
         OP_JMP:     begin dst = DST_PC; jump = 1'b1;   end
         // carry here is the flag left by the previous instruction
         OP_JNC: begin
            if (!carry) begin
               dst  = DST_PC;
               jump = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/td4_exec_unit.sv
// TD4 execute/register stage: decodes the ROM word, drives the ALU, commits one register per clock.
// Latency: one cycle per instruction; results visible right after the rising edge.
// Backpressure: none; an instruction retires every clock while rst_n is high.
// Ports: clk, rst_n; addr (PC to ROM), instr (ROM data); in_port; out_port, reg_a, reg_b, carry.
module td4_exec_unit
   import td4_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic [N-1:0] addr,
   input  logic [N+3:0] instr,
   input  logic [N-1:0] in_port,
   output logic [N-1:0] out_port,
   output logic [N-1:0] reg_a,
   output logic [N-1:0] reg_b,
   output logic         carry
);

   logic [3:0]   opcode;
   logic [N-1:0] imm;
   src_t         src;
   dst_t         dst;
   logic         jump;
   logic [N-1:0] src_val;
   logic [N-1:0] alu_y;
   logic         alu_c;

   assign opcode = instr[N+3:N];
   assign imm    = instr[N-1:0];

   td4_decoder u_dec (
      .opcode (opcode),
      .carry  (carry),
      .src    (src),
      .dst    (dst),
      .jump   (jump)
   );

   always_comb begin
      src_val = '0;
      case (src)
         SRC_A:   src_val = reg_a;
         SRC_B:   src_val = reg_b;
         SRC_IN:  src_val = in_port;
         default: src_val = '0;
      endcase
   end

   ALU #(.N(N)) u_alu (
      .A (src_val),
      .B (imm),
      .Y (alu_y),
      .C (alu_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_a    <= '0;
         reg_b    <= '0;
         out_port <= '0;
         addr     <= '0;
         carry    <= 1'b0;
      end else begin
         // flag follows the ALU on every instruction, jumps and OUT included
         carry <= alu_c;
         // a taken jump loads Im (ALU output equals Im since source is zero)
         addr  <= jump ? imm : addr + {{(N-1){1'b0}}, 1'b1};
         case (dst)
            DST_A:   reg_a    <= alu_y;
            DST_B:   reg_b    <= alu_y;
            DST_OUT: out_port <= alu_y;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_td4_exec_unit.sv
module tb_td4_exec_unit;

   logic       clk;
   logic       rst_n;
   logic [3:0] addr;
   logic [7:0] instr;
   logic [3:0] in_port;
   logic [3:0] out_port;
   logic [3:0] reg_a;
   logic [3:0] reg_b;
   logic       carry;

   logic [7:0] rom [16];

   int tests;
   int fails;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] o;
      logic [3:0] pc;
      logic       c;
   } st_t;

   st_t sb[$];

   // reference ISA state
   logic [3:0] m_a, m_b, m_o, m_pc;
   logic       m_c;

   assign instr = rom[addr];

   td4_exec_unit #(.N(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr     (addr),
      .instr    (instr),
      .in_port  (in_port),
      .out_port (out_port),
      .reg_a    (reg_a),
      .reg_b    (reg_b),
      .carry    (carry)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      m_a = 4'h0; m_b = 4'h0; m_o = 4'h0; m_pc = 4'h0; m_c = 1'b0;
      sb.delete();
   endtask

   task automatic rom_fill(input logic [7:0] v);
      for (int i = 0; i < 16; i++) rom[i] = v;
   endtask

   // Execute one instruction: model predicts, pushes, then the popped entry is checked after the edge.
   task automatic step();
      logic [7:0] iv;
      logic [3:0] op, im, sv;
      logic [4:0] sum;
      st_t        e;
      iv = rom[m_pc];
      op = iv[7:4];
      im = iv[3:0];
      case (op)
         4'h0, 4'h4:       sv = m_a;
         4'h5, 4'h1, 4'h9: sv = m_b;
         4'h2, 4'h6:       sv = in_port;
         default:          sv = 4'h0;
      endcase
      sum = {1'b0, sv} + {1'b0, im};
      if (op == 4'hF || (op == 4'hE && !m_c)) m_pc = im;
      else m_pc = m_pc + 4'h1;
      case (op)
         4'h0, 4'h3, 4'h1, 4'h2: m_a = sum[3:0];
         4'h5, 4'h7, 4'h4, 4'h6: m_b = sum[3:0];
         4'h9, 4'hB:             m_o = sum[3:0];
         default: ;
      endcase
      m_c = sum[4];
      e.a = m_a; e.b = m_b; e.o = m_o; e.pc = m_pc; e.c = m_c;
      sb.push_back(e);
      @(posedge clk);
      #1;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL sb_empty: no expectation queued");
      end else begin
         e = sb.pop_front();
         if ({reg_a, reg_b, out_port, addr, carry} !== {e.a, e.b, e.o, e.pc, e.c}) begin
            fails++;
            $display("FAIL sb_state: got a=%h b=%h out=%h pc=%h c=%b expected a=%h b=%h out=%h pc=%h c=%b",
                     reg_a, reg_b, out_port, addr, carry, e.a, e.b, e.o, e.pc, e.c);
         end
      end
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
   endtask

   task automatic release_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rom_fill(8'h00);
      rom[0] = 8'h33;  // MOV A,3
      rom[1] = 8'h05;  // ADD A,5
      apply_reset();
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         tests++;
         if ({reg_a, reg_b, out_port, addr, carry} !== 17'h0) begin
            fails++;
            $display("FAIL reset_hold: got a=%h b=%h out=%h pc=%h c=%b expected all 0",
                     reg_a, reg_b, out_port, addr, carry);
         end
      end
      release_reset();
      step();
      tests++;
      if (reg_a !== 4'h3) begin
         fails++;
         $display("FAIL reset_mov_a: got %h expected 3", reg_a);
      end
      step();
      tests++;
      if ({reg_a, carry, addr} !== {4'h8, 1'b0, 4'h2}) begin
         fails++;
         $display("FAIL reset_add_a: got a=%h c=%b pc=%h expected a=8 c=0 pc=2", reg_a, carry, addr);
      end
   endtask

   task automatic test_carry_jnc();
      rom_fill(8'h00);
      rom[0] = 8'h3F;  // MOV A,F
      rom[1] = 8'h03;  // ADD A,3
      rom[2] = 8'hE0;  // JNC 0
      rom[3] = 8'hE9;  // JNC 9
      apply_reset();
      release_reset();
      step();
      step();
      tests++;
      if ({reg_a, carry} !== {4'h2, 1'b1}) begin
         fails++;
         $display("FAIL carry_set: got a=%h c=%b expected a=2 c=1", reg_a, carry);
      end
      step();
      tests++;
      if ({addr, carry} !== {4'h3, 1'b0}) begin
         fails++;
         $display("FAIL jnc_not_taken: got pc=%h c=%b expected pc=3 c=0", addr, carry);
      end
      step();
      tests++;
      if (addr !== 4'h9) begin
         fails++;
         $display("FAIL jnc_taken: got pc=%h expected 9", addr);
      end
   endtask

   task automatic test_moves_out();
      rom_fill(8'h00);
      rom[0] = 8'h77;  // MOV B,7
      rom[1] = 8'h11;  // MOV A,B +1
      rom[2] = 8'h90;  // OUT B
      rom[3] = 8'hBC;  // OUT Im=C
      rom[4] = 8'h85;  // undefined opcode
      apply_reset();
      release_reset();
      step();
      step();
      tests++;
      if ({reg_b, reg_a} !== {4'h7, 4'h8}) begin
         fails++;
         $display("FAIL mov_regs: got b=%h a=%h expected b=7 a=8", reg_b, reg_a);
      end
      step();
      tests++;
      if (out_port !== 4'h7) begin
         fails++;
         $display("FAIL out_b: got %h expected 7", out_port);
      end
      step();
      tests++;
      if ({out_port, reg_a, reg_b} !== {4'hC, 4'h8, 4'h7}) begin
         fails++;
         $display("FAIL out_im: got out=%h a=%h b=%h expected out=c a=8 b=7", out_port, reg_a, reg_b);
      end
      step();
      tests++;
      if ({out_port, reg_a, reg_b, addr} !== {4'hC, 4'h8, 4'h7, 4'h5}) begin
         fails++;
         $display("FAIL undef_op: got out=%h a=%h b=%h pc=%h expected out=c a=8 b=7 pc=5",
                  out_port, reg_a, reg_b, addr);
      end
   endtask

   task automatic test_in();
      rom_fill(8'h00);
      rom[0] = 8'h60;  // IN B
      rom[1] = 8'h20;  // IN A
      apply_reset();
      release_reset();
      in_port = 4'hA;
      step();
      tests++;
      if (reg_b !== 4'hA) begin
         fails++;
         $display("FAIL in_b: got %h expected a", reg_b);
      end
      in_port = 4'h5;
      step();
      tests++;
      if ({reg_a, carry} !== {4'h5, 1'b0}) begin
         fails++;
         $display("FAIL in_a: got a=%h c=%b expected a=5 c=0", reg_a, carry);
      end
      in_port = 4'h0;
   endtask

   task automatic test_wrap_jmp();
      rom_fill(8'h30);  // MOV A,0 everywhere
      apply_reset();
      release_reset();
      for (int k = 0; k < 15; k++) step();
      tests++;
      if (addr !== 4'hF) begin
         fails++;
         $display("FAIL pc_top: got %h expected f", addr);
      end
      step();
      tests++;
      if (addr !== 4'h0) begin
         fails++;
         $display("FAIL pc_wrap: got %h expected 0", addr);
      end
      rom[0] = 8'hFE;  // JMP E
      step();
      tests++;
      if ({addr, carry} !== {4'hE, 1'b0}) begin
         fails++;
         $display("FAIL jmp: got pc=%h c=%b expected pc=e c=0", addr, carry);
      end
   endtask

   task automatic test_async_reset();
      rom_fill(8'h01);  // ADD A,1
      rom[0] = 8'h31;   // MOV A,1
      apply_reset();
      release_reset();
      step();
      step();
      step();
      tests++;
      if (reg_a !== 4'h3) begin
         fails++;
         $display("FAIL pre_reset_a: got %h expected 3", reg_a);
      end
      // now 1 time unit after a rising edge; pulse reset well before the next one
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      tests++;
      if ({reg_a, reg_b, out_port, addr, carry} !== 17'h0) begin
         fails++;
         $display("FAIL async_clear: got a=%h b=%h out=%h pc=%h c=%b expected all 0",
                  reg_a, reg_b, out_port, addr, carry);
      end
      rst_n = 1'b1;
      step();
      tests++;
      if ({addr, reg_a} !== {4'h1, 4'h1}) begin
         fails++;
         $display("FAIL resume: got pc=%h a=%h expected pc=1 a=1", addr, reg_a);
      end
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      rst_n   = 1'b0;
      in_port = 4'h0;
      rom_fill(8'h00);
      model_reset();
      test_reset();
      test_carry_jnc();
      test_moves_out();
      test_in();
      test_wrap_jmp();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
